// File: rtl/seq_source.sv
// Programmable arithmetic word source: launches BASE, BASE+/-STEP, ... for COUNT words
// on posedge so a negedge-capture stage downstream sees each word settled for half a period.
module seq_source #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] BASE,
    input  logic [N-1:0] STEP,
    input  logic         DIR,
    input  logic [M-1:0] COUNT,
    input  logic         HOLD,
    output logic [N-1:0] D_OUT,
    output logic         VALID,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [M-1:0] ONE_M = M'(1);

    state_t       state_q, state_d;
    logic [N-1:0] data_q,  data_d;
    logic [N-1:0] step_q,  step_d;
    logic [M-1:0] rem_q,   rem_d;
    logic         dir_q,   dir_d;
    logic         valid_q, valid_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Every output flag is registered one step ahead of its state, so no input reaches an output combinationally.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        step_d  = step_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (COUNT != '0) begin
                        data_d  = BASE;
                        step_d  = STEP;
                        dir_d   = DIR;
                        rem_d   = COUNT - ONE_M;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (!HOLD) begin
                    if (rem_q != '0) begin
                        data_d = dir_q ? (data_q - step_q) : (data_q + step_q);
                        rem_d  = rem_q - ONE_M;
                    end else begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                data_d  = '0;
                rem_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign D_OUT = data_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule
